// File: rtl/wb_write_arb.sv
// Writeback arbiter: merges the in-order pipeline result and a multi-cycle result stream onto the single RF write port.
// Optional macro WB_DRAIN_EN enables a registered upstream stall while the result FIFO is full.
module wb_write_arb #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_dst,
  input  logic [31:0] pipe_data,
  input  logic        mc_valid,
  output logic        mc_ready,
  input  logic [4:0]  mc_dst,
  input  logic [31:0] mc_data,
  output logic [4:0]  WB_Dst,
  output logic [31:0] WB_Result,
  output logic        RFWr,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  output logic        pend_rs,
  output logic        pend_rt,
  output logic        pipe_stall
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [4:0]       dst_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [AW:0]      count_q, count_d;
  logic             rfwr_q, rfwr_d;
  logic [4:0]       wb_dst_q, wb_dst_d;
  logic [31:0]      wb_data_q, wb_data_d;

  logic pipe_win_s, fifo_empty_s, mc_acc_s, pop_s, bypass_s, push_s;

  assign mc_ready  = (count_q < FULL_CNT);
  assign RFWr      = rfwr_q;
  assign WB_Dst    = wb_dst_q;
  assign WB_Result = wb_data_q;

  // Arbitration: pipeline first, then FIFO head, then direct bypass of the mc result.
  always_comb begin
    pipe_win_s   = pipe_valid && (pipe_dst != 5'd0);
    fifo_empty_s = (count_q == '0);
    mc_acc_s     = mc_valid && mc_ready;
    pop_s        = !pipe_win_s && !fifo_empty_s;
    bypass_s     = !pipe_win_s && fifo_empty_s && mc_acc_s && (mc_dst != 5'd0);
    // An mc result matching the pipeline's write in the same cycle is older, so it is dropped.
    push_s       = mc_acc_s && (mc_dst != 5'd0) && !bypass_s &&
                   !(pipe_win_s && (mc_dst == pipe_dst));

    rfwr_d    = 1'b0;
    wb_dst_d  = wb_dst_q;
    wb_data_d = wb_data_q;
    if (pipe_win_s) begin
      rfwr_d    = 1'b1;
      wb_dst_d  = pipe_dst;
      wb_data_d = pipe_data;
    end else if (pop_s) begin
      rfwr_d = live_q[head_q];
      if (live_q[head_q]) begin
        wb_dst_d  = dst_q[head_q];
        wb_data_d = data_q[head_q];
      end else begin
        wb_dst_d  = wb_dst_q;
        wb_data_d = wb_data_q;
      end
    end else if (bypass_s) begin
      rfwr_d    = 1'b1;
      wb_dst_d  = mc_dst;
      wb_data_d = mc_data;
    end else begin
      rfwr_d = 1'b0;
    end
  end

  // FIFO bookkeeping: WAW kill, pop, push and occupancy.
  always_comb begin
    live_d = live_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_win_s && live_q[i] && (dst_q[i] == pipe_dst)) begin
        live_d[i] = 1'b0;
      end else begin
        live_d[i] = live_q[i];
      end
    end
    if (pop_s) begin
      live_d[head_q] = 1'b0;
    end else begin
      live_d[head_q] = live_d[head_q];
    end
    if (push_s) begin
      live_d[tail_q] = 1'b1;
    end else begin
      live_d[tail_q] = live_d[tail_q];
    end

    head_d = pop_s  ? head_q + {{(AW-1){1'b0}}, 1'b1} : head_q;
    tail_d = push_s ? tail_q + {{(AW-1){1'b0}}, 1'b1} : tail_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rfwr_q    <= 1'b0;
      wb_dst_q  <= 5'd0;
      wb_data_q <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        dst_q[i]  <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      live_q    <= live_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rfwr_q    <= rfwr_d;
      wb_dst_q  <= wb_dst_d;
      wb_data_q <= wb_data_d;
      if (push_s) begin
        dst_q[tail_q]  <= mc_dst;
        data_q[tail_q] <= mc_data;
      end
    end
  end

  // Hazard lookup over live queued destinations; killed entries never match.
  always_comb begin
    pend_rs = 1'b0;
    pend_rt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (dst_q[i] == ID_rs) && (ID_rs != 5'd0)) begin
        pend_rs = 1'b1;
      end else begin
        pend_rs = pend_rs;
      end
      if (live_q[i] && (dst_q[i] == ID_rt) && (ID_rt != 5'd0)) begin
        pend_rt = 1'b1;
      end else begin
        pend_rt = pend_rt;
      end
    end
  end

`ifdef WB_DRAIN_EN
  logic stall_q;

  // Upstream hold lags FIFO-full by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
    end else begin
      stall_q <= (count_q == FULL_CNT);
    end
  end

  assign pipe_stall = stall_q;
`else
  assign pipe_stall = 1'b0;
`endif

endmodule

// File: tb/tb_wb_write_arb.sv
// Randomized plus directed bench for wb_write_arb against a queue-based reference model.
module tb_wb_write_arb;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, pipe_valid, mc_valid, mc_ready, RFWr, pend_rs, pend_rt, pipe_stall;
  logic [4:0]  pipe_dst, mc_dst, WB_Dst, ID_rs, ID_rt;
  logic [31:0] pipe_data, mc_data, WB_Result;

  always #5 clk = ~clk;

  wb_write_arb #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_dst(pipe_dst), .pipe_data(pipe_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_dst(mc_dst), .mc_data(mc_data),
    .WB_Dst(WB_Dst), .WB_Result(WB_Result), .RFWr(RFWr),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .pend_rs(pend_rs), .pend_rt(pend_rt),
    .pipe_stall(pipe_stall)
  );

  typedef struct {
    logic [4:0]  dst;
    logic [31:0] data;
    bit          live;
  } ent_t;

  ent_t        q[$];
  bit          mvalid = 1'b0;
  bit          last_acc;
  logic        exp_rfwr, exp_stall;
  logic [4:0]  exp_dst;
  logic [31:0] exp_data;
  int          errs = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_pend(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].live && q[i].dst == r) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: pipeline wins, else pop, else bypass; accepted mc results queue unless killed/bypassed.
  task automatic model_update();
    bit   pw, acc, bypassed, full_before;
    ent_t e;
    if (rst) begin
      last_acc  = mc_valid && (q.size() < DEPTH);
      q.delete();
      exp_rfwr  = 1'b0;
      exp_dst   = 5'd0;
      exp_data  = 32'd0;
      exp_stall = 1'b0;
      mvalid    = 1'b1;
    end else begin
      full_before = (q.size() == DEPTH);
      acc         = mc_valid && (q.size() < DEPTH);
      last_acc    = acc;
      pw          = pipe_valid && (pipe_dst != 5'd0);
      bypassed    = 1'b0;
      if (pw) begin
        exp_rfwr = 1'b1; exp_dst = pipe_dst; exp_data = pipe_data;
        foreach (q[i]) if (q[i].dst == pipe_dst) q[i].live = 1'b0;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        exp_rfwr = e.live;
        if (e.live) begin exp_dst = e.dst; exp_data = e.data; end
      end else if (acc && mc_dst != 5'd0) begin
        exp_rfwr = 1'b1; exp_dst = mc_dst; exp_data = mc_data; bypassed = 1'b1;
      end else begin
        exp_rfwr = 1'b0;
      end
      if (acc && mc_dst != 5'd0 && !bypassed && !(pw && mc_dst == pipe_dst))
        q.push_back('{dst: mc_dst, data: mc_data, live: 1'b1});
`ifdef WB_DRAIN_EN
      exp_stall = full_before;
`else
      exp_stall = 1'b0;
`endif
    end
  endtask

  // One clock: combinational checks, model advance, then registered checks.
  task automatic step();
    #1;
    if (mvalid) begin
      chk("mc_ready", {31'd0, mc_ready}, {31'd0, (q.size() < DEPTH)});
      chk("pend_rs", {31'd0, pend_rs}, {31'd0, model_pend(ID_rs)});
      chk("pend_rt", {31'd0, pend_rt}, {31'd0, model_pend(ID_rt)});
      chk("pipe_stall", {31'd0, pipe_stall}, {31'd0, exp_stall});
    end
    model_update();
    @(posedge clk);
    #1;
    if (mvalid) begin
      chk("RFWr", {31'd0, RFWr}, {31'd0, exp_rfwr});
      if (exp_rfwr) begin
        chk("WB_Dst", {27'd0, WB_Dst}, {27'd0, exp_dst});
        chk("WB_Result", WB_Result, exp_data);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; pipe_valid = 1'b0; pipe_dst = 5'd0; pipe_data = 32'd0;
    mc_valid = 1'b0; mc_dst = 5'd0; mc_data = 32'd0; ID_rs = 5'd0; ID_rt = 5'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] offers [5];
    logic [4:0] writes [$];
    int         k, accepted;

    @(negedge clk);
    do_reset();
    step();
    chk("reset RFWr", {31'd0, RFWr}, 32'd0);
    chk("reset WB_Dst", {27'd0, WB_Dst}, 32'd0);
    chk("reset WB_Result", WB_Result, 32'd0);
    chk("reset mc_ready", {31'd0, mc_ready}, 32'd1);
    chk("reset pipe_stall", {31'd0, pipe_stall}, 32'd0);

    // Lone pipe write.
    pipe_valid = 1'b1; pipe_dst = 5'd5; pipe_data = 32'h1234;
    step();
    chk("lone RFWr", {31'd0, RFWr}, 32'd1);
    chk("lone WB_Dst", {27'd0, WB_Dst}, 32'd5);
    chk("lone WB_Result", WB_Result, 32'h1234);
    idle_inputs();
    step();
    chk("lone idle RFWr", {31'd0, RFWr}, 32'd0);

    // Bypass with empty FIFO.
    mc_valid = 1'b1; mc_dst = 5'd7; mc_data = 32'hA5A5;
    #1 chk("bypass mc_ready", {31'd0, mc_ready}, 32'd1);
    step();
    chk("bypass WB_Dst", {27'd0, WB_Dst}, 32'd7);
    chk("bypass WB_Result", WB_Result, 32'hA5A5);
    chk("bypass count", q.size(), 32'd0);
    idle_inputs();
    step();

    // Conflict and queue: pipe busy for 6 cycles while mc offers 8..12.
    offers = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
    k = 0; accepted = 0;
    for (int c = 0; c < 6; c++) begin
      pipe_valid = 1'b1; pipe_dst = 5'd3; pipe_data = 32'h300 + c;
      mc_valid = (k < 5); mc_dst = offers[k < 5 ? k : 4]; mc_data = 32'h100 + mc_dst;
      step();
      if (last_acc && k < 5) begin k++; accepted++; end
    end
    chk("conflict accepted", accepted, 32'd4);
    ID_rs = 5'd9;
    #1;
    chk("conflict mc_ready full", {31'd0, mc_ready}, 32'd0);
    chk("conflict pend_rs 9", {31'd0, pend_rs}, 32'd1);
    pipe_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      mc_valid = (k < 5); mc_dst = offers[k < 5 ? k : 4]; mc_data = 32'h100 + mc_dst;
      step();
      if (last_acc && k < 5) k++;
      if (RFWr) writes.push_back(WB_Dst);
    end
    chk("drain write count", writes.size(), 32'd5);
    for (int i = 0; i < 5 && i < writes.size(); i++)
      chk("drain order", {27'd0, writes[i]}, {27'd0, offers[i]});

    // WAW kill.
    do_reset();
    pipe_valid = 1'b1; pipe_dst = 5'd1; pipe_data = 32'd7;
    mc_valid = 1'b1; mc_dst = 5'd4; mc_data = 32'd1;
    step();
    mc_valid = 1'b0; pipe_dst = 5'd4; pipe_data = 32'd2; ID_rs = 5'd4;
    #1 chk("waw pend before", {31'd0, pend_rs}, 32'd1);
    step();
    chk("waw WB_Dst", {27'd0, WB_Dst}, 32'd4);
    chk("waw WB_Result", WB_Result, 32'd2);
    chk("waw pend after", {31'd0, pend_rs}, 32'd0);
    pipe_valid = 1'b0;
    step();
    chk("waw killed pop RFWr", {31'd0, RFWr}, 32'd0);

    // Zero destination handshake.
    idle_inputs();
    mc_valid = 1'b1; mc_dst = 5'd0; mc_data = 32'hDEAD;
    #1 chk("zero mc_ready", {31'd0, mc_ready}, 32'd1);
    chk("zero pend_rs", {31'd0, pend_rs}, 32'd0);
    step();
    chk("zero RFWr", {31'd0, RFWr}, 32'd0);
    chk("zero count", q.size(), 32'd0);

    // Reset mid-queue.
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      pipe_valid = 1'b1; pipe_dst = 5'd2; pipe_data = 32'd5;
      mc_valid = 1'b1; mc_dst = 5'(20 + c); mc_data = 32'd9;
      step();
    end
    chk("midq count", q.size(), 32'd3);
    ID_rs = 5'd20; ID_rt = 5'd21;
    rst = 1'b1; mc_valid = 1'b0;
    step();
    rst = 1'b0; pipe_valid = 1'b0;
    chk("midq RFWr", {31'd0, RFWr}, 32'd0);
    chk("midq mc_ready", {31'd0, mc_ready}, 32'd1);
    chk("midq pend_rs", {31'd0, pend_rs}, 32'd0);
    chk("midq pend_rt", {31'd0, pend_rt}, 32'd0);
    step();
    chk("midq no write", {31'd0, RFWr}, 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 249) == 0);
      pipe_valid = ($urandom_range(0, 99) < 55);
      if (exp_stall) pipe_valid = 1'b0;
      pipe_dst   = 5'($urandom_range(0, 7));
      pipe_data  = $urandom;
      mc_valid   = ($urandom_range(0, 99) < 50);
      mc_dst     = 5'($urandom_range(0, 7));
      mc_data    = $urandom;
      ID_rs      = 5'($urandom_range(0, 7));
      ID_rt      = 5'($urandom_range(0, 7));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/wb_write_arb.md
Name: wb_write_arb

Overview:
- Writeback-side producer for the register-file write port (WB_Dst / WB_Result / RFWr).
- Merges two result streams into the single RF write port, one write per cycle:
  - the in-order pipeline result (fixed priority, never back-pressured);
  - a multi-cycle unit result (mul/div, late load) on a valid/ready handshake.
- Multi-cycle results lose arbitration while the pipeline writes; they are held in a small FIFO.
- The FIFO contents are exported as pending-destination hazard hits for the ID stage.

Parameters:
- DEPTH, 4, multi-cycle result FIFO entries (power of 2, >=2)
- AW, 2, log2(DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- pipe_valid  in  1  pipeline result present this cycle
- pipe_dst  in  5  pipeline destination register
- pipe_data  in  32  pipeline result
- mc_valid  in  1  multi-cycle result offered
- mc_ready  out  1  multi-cycle result accepted when mc_valid & mc_ready
- mc_dst  in  5  multi-cycle destination register
- mc_data  in  32  multi-cycle result
- WB_Dst  out  5  RF write address (registered)
- WB_Result  out  32  RF write data (registered)
- RFWr  out  1  RF write enable (registered)
- ID_rs  in  5  ID source register A
- ID_rt  in  5  ID source register B
- pend_rs  out  1  ID_rs has a live FIFO entry
- pend_rt  out  1  ID_rt has a live FIFO entry
- pipe_stall  out  1  upstream hold request (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values:
  - RFWr=0, WB_Dst=0, WB_Result=0;
  - FIFO empty: count=0, all entries invalid, head/tail pointers =0;
  - pend_rs=pend_rt=0, pipe_stall=0.
- Reset mid-operation discards every queued result. No RF write occurs in the cycle after rst.
- mc_ready = (count < DEPTH). It is combinational from registered state and independent of mc_valid.
- Output register: exactly one source is chosen per cycle and registered. Its effect is visible on WB_* in the next cycle, so latency is 1 cycle.
- Priority per cycle:
  1. pipe_valid && pipe_dst!=0: write the pipe result.
  2. Else if the FIFO is non-empty: pop the head. Set RFWr=1 only if the head is live; a killed head pops with RFWr=0.
  3. Else if mc_valid && mc_ready && mc_dst!=0: bypass the mc result directly to the output; it is not enqueued.
  4. Else RFWr=0, and WB_Dst/WB_Result hold their previous values.
- Enqueue: an accepted mc handshake is pushed at the tail when it was not bypassed and mc_dst!=0.
- mc_dst==0: the handshake completes, the result is dropped, and no entry is used.
- Simultaneous push and pop: both take effect and count is unchanged. A push into a full FIFO never occurs, because mc_ready is 0.
- WAW kill, applied when pipeline case 1 fires:
  - every live FIFO entry with dst==pipe_dst is marked killed;
  - an mc result accepted in that same cycle with mc_dst==pipe_dst is dropped. The pipeline result is treated as youngest.
- Hazard outputs:
  - pend_rs = OR over live entries with dst==ID_rs, and ID_rs!=0;
  - pend_rt is the same for ID_rt;
  - both are combinational from registered FIFO state.
  - Killed entries and the output register are excluded, since the RF already bypasses the current WB write.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.

Optional Feature:
- Macro: WB_DRAIN_EN.
- Defined:
  - pipe_stall = (count==DEPTH), registered. It asserts the cycle after the FIFO becomes full.
  - Upstream must hold pipe_valid=0 while pipe_stall=1, so the FIFO drains at one entry per cycle.
  - pipe_stall deasserts the cycle after count drops below DEPTH.
- Not defined:
  - pipe_stall is tied 0.
  - A continuously valid pipeline may starve the FIFO indefinitely.

Test Plan:
- Lone pipe: after reset, pipe_valid=1, dst=5, data=32'h1234 -> next cycle RFWr=1, WB_Dst=5, WB_Result=32'h1234; following idle cycle RFWr=0.
- Bypass: FIFO empty, pipe idle, mc_valid=1, dst=7, data=32'hA5A5 -> mc_ready=1; next cycle RFWr=1, WB_Dst=7, WB_Result=32'hA5A5; count stays 0.
- Conflict and queue:
  - pipe dst=3 every cycle for 6 cycles while mc offers dst=8,9,10,11,12 back-to-back;
  - expect 4 accepted, mc_ready=0 at count=4, pend_rs=1 for ID_rs=9;
  - after pipe stops, 4 writes in order 8,9,10,11 on consecutive cycles, then 12.
- WAW kill: FIFO holds dst=4 data=1; pipe writes dst=4 data=2 -> WB shows 4/2, later head pops with RFWr=0, pend_rs for ID_rs=4 drops to 0 the cycle after the kill.
- Zero dst: mc_valid dst=0 -> handshake completes, count unchanged, no RF write; ID_rs=0 never raises pend_rs.
- Reset mid-queue: count=3, assert rst one cycle -> RFWr=0, count=0, pend_*=0, mc_ready=1. With WB_DRAIN_EN, a full FIFO gives pipe_stall=1 one cycle later, clearing after the first pop.
